temp_sampler: RTL

TEMP_SAMPLER -- requirements
Module: temp_sampler

---
 rtl/temp_sampler_pkg.sv | 27 ++
 rtl/temp_avg4.sv | 51 +++++
 rtl/temp_sampler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/temp_sampler_pkg.sv
// Purpose : shared types and sizes for the temperature sampler slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, ADC sample width, history depth, sum width
// and the mean helper used by the averaging history.
package temp_sampler_pkg;

  localparam int ADC_W      = 8;
  localparam int HIST_DEPTH = 4;
  // 4 x 255 = 1020 fits exactly in 10 bits.
  localparam int SUM_W      = 10;
  localparam int FILL_W     = $clog2(HIST_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Divide-by-4 by dropping the two LSBs: truncation, never rounding.
  function automatic logic [ADC_W-1:0] mean4(input logic [SUM_W-1:0] sum);
    return sum[SUM_W-1:2];
  endfunction

endpackage

// File: rtl/temp_avg4.sv
// Purpose : 4-entry sample history with truncated mean and full flag.
// Latency : mean/full are combinational and describe the window as it will
//           stand once din is pushed, so the caller can register them on the push edge.
// Backpressure: none; push is accepted every cycle it is asserted.
//
// Ports:
//   clk   - system clock (rising edge)
//   clear - synchronous clear of history, running sum and fill count
//   push  - shift din into the history, oldest entry dropped
//   din   - raw ADC byte
//   mean  - (sum of window including din)[9:2]
//   full  - window including din holds HIST_DEPTH real samples
module temp_avg4
  import temp_sampler_pkg::*;
(
  input  logic             clk,
  input  logic             clear,
  input  logic             push,
  input  logic [ADC_W-1:0] din,
  output logic [ADC_W-1:0] mean,
  output logic             full
);

  logic [HIST_DEPTH-1:0][ADC_W-1:0] hist;
  logic [SUM_W-1:0]                 sum;
  logic [SUM_W-1:0]                 sum_nxt;
  logic [FILL_W-1:0]                fill;

  // Running sum: add the newcomer, remove the entry being dropped. The true
  // result is always 0..1020, so the modulo-1024 arithmetic is exact.
  always_comb begin
    sum_nxt = sum + SUM_W'(din) - SUM_W'(hist[HIST_DEPTH-1]);
    mean    = mean4(sum_nxt);
    full    = (fill >= FILL_W'(HIST_DEPTH - 1));
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      hist <= '0;
      sum  <= '0;
      fill <= '0;
    end else if (push) begin
      hist <= {hist[HIST_DEPTH-2:0], din};
      sum  <= sum_nxt;
      if (fill != FILL_W'(HIST_DEPTH)) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/temp_sampler.sv
// Purpose : periodic serial read of an 8-bit ADC, optional 4-sample mean,
//           setpoint compare.
// Latency : gt/t_g_gt/gt_valid register on the edge that ends DONE.
// Backpressure: none; results are a one-cycle gt_valid pulse, no handshake.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-low reset
//   adc_do   - ADC serial data, asynchronous, 2-flop synchronized
//   adc_cs_n - ADC chip select, active low
//   adc_sclk - ADC serial clock, CLK_DIV clk cycles per half period
//   target   - setpoint code
//   gt       - filtered (or raw) temperature code
//   t_g_gt   - target > gt, evaluated at update time
//   gt_valid - one-cycle pulse when gt/t_g_gt update
//
// Build option: define TEMP_SAMPLER_AVG_EN to compile in the 4-sample mean;
// otherwise gt is the raw byte of every conversion.
module temp_sampler
  import temp_sampler_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int GAP     = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adc_do,
  output logic             adc_cs_n,
  output logic             adc_sclk,
  input  logic [ADC_W-1:0] target,
  output logic [ADC_W-1:0] gt,
  output logic             t_g_gt,
  output logic             gt_valid
);

  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);

  state_t           state;
  logic [15:0]      gap_cnt;
  logic [7:0]       div_cnt;
  logic [2:0]       bit_cnt;
  logic [1:0]       sync;
  logic [ADC_W-1:0] shift_reg;

  // Result presented to the output registers during DONE.
  logic [ADC_W-1:0] res_dat;
  logic             res_vld;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], adc_do};
    end
  end

`ifdef TEMP_SAMPLER_AVG_EN
  logic avg_push;
  logic avg_clear;

  assign avg_push  = (state == DONE);
  assign avg_clear = ~rst;

  temp_avg4 u_avg (
    .clk   (clk),
    .clear (avg_clear),
    .push  (avg_push),
    .din   (shift_reg),
    .mean  (res_dat),
    .full  (res_vld)
  );
`else
  assign res_dat = shift_reg;
  assign res_vld = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      adc_cs_n  <= 1'b1;
      adc_sclk  <= 1'b0;
      gt        <= '0;
      t_g_gt    <= 1'b0;
      gt_valid  <= 1'b0;
    end else begin
      gt_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt  <= '0;
            div_cnt  <= '0;
            adc_cs_n <= 1'b0;
            adc_sclk <= 1'b0;
            state    <= START;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end

        START, SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            adc_sclk <= ~adc_sclk;
            // Last clk of a high phase: end of one full sclk period.
            if (adc_sclk) begin
              if (state == START) begin
                // Mux-settle period complete; nothing captured.
                bit_cnt <= '0;
                state   <= SHIFT;
              end else begin
                shift_reg <= {shift_reg[ADC_W-2:0], sync[1]};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  adc_cs_n <= 1'b1;
                  adc_sclk <= 1'b0;
                  state    <= DONE;
                end
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        DONE: begin
          gap_cnt <= '0;
          state   <= IDLE;
          if (res_vld) begin
            gt       <= res_dat;
            t_g_gt   <= (target > res_dat);
            gt_valid <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
